// File: rtl/dual_sram_responder.sv
// Single-word read/write responder driving two external asynchronous 16-bit SRAMs.
// Optional: define SRAM_READBACK_VERIFY_EN to re-read each write and pulse err on mismatch.
module dual_sram_responder #(
  parameter int WR_PULSE = 2,
  parameter int RD_WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        re,
  input  logic        we,
  input  logic [16:0] addr,
  input  logic [15:0] data_in,
  output logic        done,
  output logic [15:0] data_out,
  output logic        busy,
  output logic        err,
  output logic        ram1EN,
  output logic        ram1OE,
  output logic        ram1WE,
  output logic [15:0] ram_addr1,
  inout  wire  [15:0] ram_data1,
  output logic        ram2EN,
  output logic        ram2OE,
  output logic        ram2WE,
  output logic [15:0] ram_addr2,
  inout  wire  [15:0] ram_data2
);

  typedef enum logic [3:0] {
    S_IDLE, S_WSETUP, S_WPULSE, S_WHOLD, S_VSETUP, S_VWAIT, S_RSETUP, S_RWAIT, S_DONE
  } state_t;

  state_t      r_state, w_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_sel, w_sel, w_accept;
  logic [15:0] r_wdata;
  logic        r_drv1, r_drv2;
  logic        w_en_n, w_oe_n, w_we_n, w_drv;
  logic [15:0] w_rdbus;

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_accept  = 1'b0;
    case (r_state)
      S_IDLE: if (en && (re || we)) begin
        w_accept = 1'b1;
        w_nxt    = we ? S_WSETUP : S_RSETUP;
      end
      S_WSETUP: begin
        w_nxt     = S_WPULSE;
        w_cnt_nxt = 16'(WR_PULSE - 1);
      end
      S_WPULSE: if (r_cnt == '0) w_nxt = S_WHOLD;
                else w_cnt_nxt = r_cnt - 16'd1;
`ifdef SRAM_READBACK_VERIFY_EN
      S_WHOLD:  w_nxt = S_VSETUP;
`else
      S_WHOLD:  w_nxt = S_DONE;
`endif
      S_VSETUP: begin
        w_nxt     = S_VWAIT;
        w_cnt_nxt = 16'(RD_WAIT - 1);
      end
      S_VWAIT:  if (r_cnt == '0) w_nxt = S_DONE;
                else w_cnt_nxt = r_cnt - 16'd1;
      S_RSETUP: begin
        w_nxt     = S_RWAIT;
        w_cnt_nxt = 16'(RD_WAIT - 1);
      end
      S_RWAIT:  if (r_cnt == '0) w_nxt = S_DONE;
                else w_cnt_nxt = r_cnt - 16'd1;
      S_DONE:   w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  // Pin levels are decoded from the next state so the registered pins line up with the state.
  always_comb begin
    w_en_n = 1'b1;
    w_oe_n = 1'b1;
    w_we_n = 1'b1;
    w_drv  = 1'b0;
    case (w_nxt)
      S_WSETUP, S_WHOLD: begin
        w_en_n = 1'b0;
        w_drv  = 1'b1;
      end
      S_WPULSE: begin
        w_en_n = 1'b0;
        w_we_n = 1'b0;
        w_drv  = 1'b1;
      end
      S_VSETUP, S_VWAIT, S_RSETUP, S_RWAIT: begin
        w_en_n = 1'b0;
        w_oe_n = 1'b0;
      end
      default: ;
    endcase
  end

  assign w_sel     = w_accept ? addr[16] : r_sel;
  assign w_rdbus   = r_sel ? ram_data2 : ram_data1;
  assign ram_data1 = r_drv1 ? r_wdata : 16'hzzzz;
  assign ram_data2 = r_drv2 ? r_wdata : 16'hzzzz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sel     <= 1'b0;
      r_wdata   <= '0;
      r_drv1    <= 1'b0;
      r_drv2    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      data_out  <= '0;
      ram1EN    <= 1'b1;
      ram1OE    <= 1'b1;
      ram1WE    <= 1'b1;
      ram2EN    <= 1'b1;
      ram2OE    <= 1'b1;
      ram2WE    <= 1'b1;
      ram_addr1 <= '0;
      ram_addr2 <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_sel   <= addr[16];
        r_wdata <= data_in;
        if (addr[16]) ram_addr2 <= addr[15:0];
        else          ram_addr1 <= addr[15:0];
      end
      ram1EN <= w_sel  | w_en_n;
      ram1OE <= w_sel  | w_oe_n;
      ram1WE <= w_sel  | w_we_n;
      ram2EN <= !w_sel | w_en_n;
      ram2OE <= !w_sel | w_oe_n;
      ram2WE <= !w_sel | w_we_n;
      r_drv1 <= !w_sel & w_drv;
      r_drv2 <= w_sel & w_drv;
      done   <= (w_nxt == S_DONE);
      busy   <= (w_nxt != S_IDLE) && (w_nxt != S_DONE);
      if (r_state == S_RWAIT && w_nxt == S_DONE) data_out <= w_rdbus;
    end
  end

`ifdef SRAM_READBACK_VERIFY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else      err <= (r_state == S_VWAIT) && (w_nxt == S_DONE) && (w_rdbus != r_wdata);
  end
`else
  assign err = 1'b0;
`endif

endmodule
